// File: rtl/am27s27_arb_pkg.sv
// Shared definitions for the am27s27 PROM arbiter: FSM state codes and
// the round-robin slot helper used by the picker.
package am27s27_arb_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    // Requester index examined at scan step k, starting just after 'last'.
    function automatic int unsigned rr_slot(input int unsigned last,
                                            input int unsigned k,
                                            input int unsigned n);
        return (last + 1 + k) % n;
    endfunction

endpackage

// File: rtl/am27s27_rrpick.sv
// Combinational round-robin picker: the first asserted request found when
// scanning upward from the requester after 'last', wrapping at NREQ.
module am27s27_rrpick
    import am27s27_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   index,
    output logic            any
);

    int unsigned slot;

    // Scan all requesters in round-robin order; the first hit wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        slot   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            slot = rr_slot(32'(last), k, NREQ);
            if (!any && req[slot]) begin
                any          = 1'b1;
                index        = slot[IW-1:0];
                onehot[slot] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am27s27_arb.sv
// Round-robin arbiter sharing one am27s27 registered PROM among NREQ
// requesters. One read accepted per clock, data returned one clock later;
// a stalled owner keeps re-registering the held address so rdata is stable.
module am27s27_arb
    import am27s27_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AWIDTH-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    input  logic [NREQ-1:0]        rready,
    output logic [NREQ-1:0]        rvalid,
    output logic [WIDTH-1:0]       rdata,
    output logic [AWIDTH-1:0]      rom_a,
    input  logic [WIDTH-1:0]       rom_q,
    output logic                   rom_e1_,
    output logic                   rom_e2_
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [0:0]        state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     last;
    logic [AWIDTH-1:0] hold_a;

    logic [NREQ-1:0]   pk_onehot;
    logic [IW-1:0]     pk_index;
    logic              pk_any;

    logic              valid;
    logic              issue;
    logic              take;

    am27s27_rrpick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .onehot (pk_onehot),
        .index  (pk_index),
        .any    (pk_any)
    );

    assign valid = (state == S_VALID);
    // A new read may start when idle or when the current owner drains its data.
    assign issue = !valid || rready[owner];
    // No read is accepted while reset is held.
    assign take  = issue && pk_any && !rst;

    // Grant, PROM address and enable decode.
    always_comb begin
        gnt     = take ? pk_onehot : '0;
        rom_a   = take ? addr[pk_index*AWIDTH +: AWIDTH] : hold_a;
        // Enable the PROM register for a new read or to re-read during a stall.
        rom_e2_ = !(take || (valid && !issue));
        rom_e1_ = !valid;
    end

    // Read-data steering to the current owner.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (valid) begin
            rvalid[owner] = 1'b1;
            rdata         = rom_q;
        end
    end

    // FSM and owner/round-robin/held-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            owner  <= '0;
            last   <= IW'(NREQ - 1);
            hold_a <= '0;
        end else if (take) begin
            state  <= S_VALID;
            owner  <= pk_index;
            last   <= pk_index;
            hold_a <= addr[pk_index*AWIDTH +: AWIDTH];
        end else if (issue) begin
            state  <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_am27s27_arb.sv
// Self-checking bench for am27s27_arb with a behavioural am27s27 PROM
// (q = ~a[7:0]) and a transaction-level reference model.
module tb_am27s27_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [35:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rready;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic [8:0]  rom_a;
    logic [7:0]  rom_q;
    logic        rom_e1_;
    logic        rom_e2_;

    logic [7:0]  prom_reg = 8'h00;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_busy;
    int         m_owner;
    int         m_last;
    logic [8:0] m_hold;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    // PROM: pipeline register loads on clk when e2_ low; e1_ gates output.
    always @(posedge clk) if (!rom_e2_) prom_reg <= ~rom_a[7:0];
    assign rom_q = rom_e1_ ? 8'h00 : prom_reg;

    am27s27_arb #(
        .NREQ   (4),
        .AWIDTH (9),
        .WIDTH  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .gnt     (gnt),
        .rready  (rready),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rom_a   (rom_a),
        .rom_q   (rom_q),
        .rom_e1_ (rom_e1_),
        .rom_e2_ (rom_e2_)
    );

    function automatic int model_pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++)
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rready = '1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'($urandom) | 4'b0001;
        rready = 4'($urandom);
        addr = {4{9'($urandom)}};
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        checks++; if (rom_e1_ !== 1'b1 || rom_e2_ !== 1'b1) begin errors++; $display("FAIL reset_enables: got e1_=%b e2_=%b expected 1 1", rom_e1_, rom_e2_); end
        rst = 1'b0;
        req = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || rvalid !== 4'b0000 || rdata !== 8'h00 || rom_e1_ !== 1'b1 || rom_e2_ !== 1'b1 || rom_a !== 9'h000) begin
                errors++;
                $display("FAIL idle_hold: got gnt=%b rvalid=%b rdata=%h e1_=%b e2_=%b a=%h expected 0000 0000 00 1 1 000",
                         gnt, rvalid, rdata, rom_e1_, rom_e2_, rom_a);
            end
        end
        next_cycle();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        addr = '0;
        addr[8:0] = 9'h003;
        rready = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        checks++; if (rom_a !== 9'h003 || rom_e2_ !== 1'b0) begin errors++; $display("FAIL single_rom: got a=%h e2_=%b expected 003 0", rom_a, rom_e2_); end
        next_cycle();
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid: got %b expected 0001", rvalid); end
        checks++; if (rdata !== 8'hFC) begin errors++; $display("FAIL single_rdata: got %h expected fc", rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid !== 4'b0000 || rom_e1_ !== 1'b1) begin errors++; $display("FAIL single_idle: got rvalid=%b e1_=%b expected 0000 1", rvalid, rom_e1_); end
        next_cycle();
    endtask

    task automatic test_rr_sweep();
        logic [7:0] exp_d [4] = '{8'hFE, 8'hAA, 8'h7F, 8'h11};
        do_reset();
        addr = {9'h1EE, 9'h080, 9'h055, 9'h001};
        req = 4'b1111;
        rready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'(1 << (k % 4))) begin errors++; $display("FAIL sweep_gnt%0d: got %b expected %b", k, gnt, 4'(1 << (k % 4))); end
            if (k > 0) begin
                checks++;
                if (rvalid !== 4'(1 << ((k - 1) % 4)) || rdata !== exp_d[(k - 1) % 4]) begin
                    errors++;
                    $display("FAIL sweep_data%0d: got rvalid=%b rdata=%h expected %b %h", k, rvalid, rdata, 4'(1 << ((k - 1) % 4)), exp_d[(k - 1) % 4]);
                end
            end
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001 || rdata !== 8'hFE) begin errors++; $display("FAIL sweep_last: got rvalid=%b rdata=%h expected 0001 fe", rvalid, rdata); end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        addr = '0;
        addr[17:9] = 9'h0CE;
        addr[26:18] = 9'h10A;
        req = 4'b0010;
        rready = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_first_gnt: got %b expected 0010", gnt); end
        next_cycle();
        req = 4'b0100;
        rready = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 4'b0010 || rdata !== 8'h31 || gnt !== 4'b0000 || rom_e2_ !== 1'b0 || rom_a !== 9'h0CE) begin
                errors++;
                $display("FAIL stall_hold%0d: got rvalid=%b rdata=%h gnt=%b e2_=%b a=%h expected 0010 31 0000 0 0ce",
                         c, rvalid, rdata, gnt, rom_e2_, rom_a);
            end
            next_cycle();
        end
        rready = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_release_gnt: got %b expected 0100", gnt); end
        next_cycle();
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0100 || rdata !== 8'hF5) begin errors++; $display("FAIL stall_next: got rvalid=%b rdata=%h expected 0100 f5", rvalid, rdata); end
        next_cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        addr = {9'h033, 9'h0, 9'h0, 9'h044};
        req = 4'b1001;
        rready = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b expected 1000", gnt); end
        checks++; if (rvalid !== 4'b0001 || rdata !== 8'hBB) begin errors++; $display("FAIL wrap_data: got rvalid=%b rdata=%h expected 0001 bb", rvalid, rdata); end
        next_cycle();
        req = '0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        addr = {9'h0, 9'h0, 9'h012, 9'h003};
        req = 4'b0001;
        rready = 4'b1111;
        next_cycle();
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL areset_pre: got %b expected 0001", rvalid); end
        rst = 1'b1;
        #1;
        checks++; if (rvalid !== 4'b0000 || rom_e1_ !== 1'b1) begin errors++; $display("FAIL areset_drop: got rvalid=%b e1_=%b expected 0000 1", rvalid, rom_e1_); end
        next_cycle();
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL areset_gnt: got %b expected 0010", gnt); end
        next_cycle();
        req = '0;
        next_cycle();
    endtask

    task automatic test_random();
        logic [3:0] exp_gnt, exp_rvalid, gprev;
        logic [7:0] exp_rdata;
        logic [8:0] exp_a, wa;
        logic       exp_e1, exp_e2, iss;
        int         w;
        do_reset();
        m_busy = 0; m_owner = 0; m_last = 3; m_hold = '0; m_data = '0;
        gprev = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || gprev[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    addr[i*9 +: 9] = 9'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
                rready[i] = ($urandom_range(0, 3) != 0);
            end
            iss = !m_busy || rready[m_owner];
            w = iss ? model_pick(req, m_last) : -1;
            wa = (w >= 0) ? addr[w*9 +: 9] : 9'h000;
            exp_gnt    = (w >= 0) ? 4'(1 << w) : 4'b0000;
            exp_rvalid = m_busy ? 4'(1 << m_owner) : 4'b0000;
            exp_rdata  = m_busy ? m_data : 8'h00;
            exp_a      = (w >= 0) ? wa : m_hold;
            exp_e1     = !m_busy;
            exp_e2     = !((w >= 0) || (m_busy && !iss));
            @(negedge clk);
            checks++;
            if (gnt !== exp_gnt || rvalid !== exp_rvalid || rdata !== exp_rdata ||
                rom_a !== exp_a || rom_e1_ !== exp_e1 || rom_e2_ !== exp_e2) begin
                errors++;
                $display("FAIL random_c%0d: got gnt=%b rvalid=%b rdata=%h a=%h e1_=%b e2_=%b expected %b %b %h %h %b %b",
                         c, gnt, rvalid, rdata, rom_a, rom_e1_, rom_e2_,
                         exp_gnt, exp_rvalid, exp_rdata, exp_a, exp_e1, exp_e2);
            end
            gprev = exp_gnt;
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_last = w; m_hold = wa; m_data = ~wa[7:0];
            end else if (iss) begin
                m_busy = 0;
            end
            next_cycle();
        end
        req = '0;
        rready = '1;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        addr = '0;
        rready = '0;
        #1;
        test_reset();
        test_single();
        test_rr_sweep();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
